// File: rtl/rr_arb_pkg.sv
// Shared constants and pointer helper for the round-robin stream arbiter.
package rr_arb_pkg;

   localparam int unsigned MAX_NUM_REQ = 32;
   localparam int unsigned MAX_IDX_W   = 5;
   localparam int unsigned GRANT_CNT_W = 16;

   // The wrap is explicit so non-power-of-2 requester counts never overrun.
   function automatic logic [MAX_IDX_W-1:0] wrap_inc(input logic [MAX_IDX_W-1:0] idx,
                                                     input int unsigned n);
      if ({27'd0, idx} == n - 1) return '0;
      return idx + 5'd1;
   endfunction

endpackage

// File: rtl/rr_prio_select.sv
// Combinational find-first-valid, searching upward from a pointer with wrap.
module rr_prio_select
   import rr_arb_pkg::*;
#(
   parameter int unsigned NUM_REQ = 4,
   localparam int unsigned IDX_W = $clog2(NUM_REQ)
) (
   input  logic [NUM_REQ-1:0] valid,
   input  logic [IDX_W-1:0]   ptr,
   output logic [IDX_W-1:0]   sel,
   output logic               any_valid
);

   int unsigned      cand;
   logic [IDX_W-1:0] cand_idx;

   // The first hit in search order wins; later candidates are ignored once found.
   always_comb begin
      sel       = '0;
      any_valid = 1'b0;
      cand      = 0;
      cand_idx  = '0;
      for (int unsigned k = 0; k < NUM_REQ; k++) begin
         cand = 32'(ptr) + k;
         if (cand >= NUM_REQ) cand = cand - NUM_REQ;
         cand_idx = IDX_W'(cand);
         if (!any_valid && valid[cand_idx]) begin
            any_valid = 1'b1;
            sel       = cand_idx;
         end
      end
   end

endmodule

// File: rtl/rr_stream_arbiter.sv
// Burst-aware round-robin N:1 ready/valid arbiter with zero-latency selection.
// Optional per-requester burst counters: define RR_STREAM_ARBITER_GRANT_CNT_EN.
module rr_stream_arbiter
   import rr_arb_pkg::*;
#(
   parameter int unsigned NUM_REQ = 4,
   parameter type T = logic [31:0],
   localparam int unsigned IDX_W = $clog2(NUM_REQ)
) (
   input  logic               clk_i,
   input  logic               rst_ni,
   input  logic [NUM_REQ-1:0] req_valid_i,
   output logic [NUM_REQ-1:0] req_ready_o,
   input  T                   req_bits_i [NUM_REQ],
   input  logic [NUM_REQ-1:0] req_last_i,
   output logic               out_valid_o,
   input  logic               out_ready_i,
   output T                   out_bits_o,
   output logic               out_last_o,
   output logic [IDX_W-1:0]   out_idx_o
`ifdef RR_STREAM_ARBITER_GRANT_CNT_EN
   ,
   output logic [GRANT_CNT_W-1:0] grant_cnt_o [NUM_REQ]
`endif
);

   logic [IDX_W-1:0] rr_ptr;
   logic [IDX_W-1:0] lock_idx_q;
   logic             lock_q;
   logic [IDX_W-1:0] free_sel;
   logic [IDX_W-1:0] sel;
   logic             any_valid;
   logic             fire;
   logic             burst_done;

   rr_prio_select #(
      .NUM_REQ(NUM_REQ)
   ) u_select (
      .valid    (req_valid_i),
      .ptr      (rr_ptr),
      .sel      (free_sel),
      .any_valid(any_valid)
   );

   // A held grant overrides the rotating search until its last beat is accepted.
   assign sel         = lock_q ? lock_idx_q : free_sel;
   assign out_valid_o = req_valid_i[sel];
   assign out_bits_o  = req_bits_i[sel];
   assign out_last_o  = req_last_i[sel];
   assign out_idx_o   = sel;
   assign fire        = out_valid_o & out_ready_i;
   assign burst_done  = fire & out_last_o;

   always_comb begin
      req_ready_o = '0;
      if (lock_q || any_valid) req_ready_o[sel] = out_ready_i;
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         rr_ptr     <= '0;
         lock_q     <= 1'b0;
         lock_idx_q <= '0;
      end else begin
         lock_q     <= out_valid_o & ~burst_done;
         lock_idx_q <= sel;
         if (burst_done) rr_ptr <= IDX_W'(wrap_inc(MAX_IDX_W'(sel), NUM_REQ));
      end
   end

`ifdef RR_STREAM_ARBITER_GRANT_CNT_EN
   // One count per completed burst, saturating rather than wrapping.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         for (int i = 0; i < NUM_REQ; i++) grant_cnt_o[i] <= '0;
      end else if (burst_done && grant_cnt_o[sel] != '1) begin
         grant_cnt_o[sel] <= grant_cnt_o[sel] + 1'b1;
      end
   end
`endif

endmodule

// File: tb/tb_rr_stream_arbiter.sv
// Self-checking bench for rr_stream_arbiter: directed table, corner sequences, random vs model.
module tb_rr_stream_arbiter;

   logic        clk;
   logic        rst_n;
   logic [3:0]  req_valid;
   logic [3:0]  req_ready;
   logic [31:0] req_bits [4];
   logic [3:0]  req_last;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] out_bits;
   logic        out_last;
   logic [1:0]  out_idx;
`ifdef RR_STREAM_ARBITER_GRANT_CNT_EN
   logic [15:0] grant_cnt [4];
`endif

   int n_cmp = 0;
   int n_bad = 0;

   // Reference model: rotation start, current burst owner (-1 = none), burst counts
   int m_ptr;
   int m_owner;
   int m_cnt [4];
   int p_sel;
   bit p_valid;
   bit p_fire;
   bit p_last;

   typedef struct {
      logic [3:0] valid;
      logic [3:0] last;
      logic       ready;
      logic       exp_valid;
      int         exp_idx;
      logic [3:0] exp_ready;
   } vec_t;

   vec_t vecs [14];
   int   rem [4];

   rr_stream_arbiter #(
      .NUM_REQ(4),
      .T(logic [31:0])
   ) dut (
      .clk_i      (clk),
      .rst_ni     (rst_n),
      .req_valid_i(req_valid),
      .req_ready_o(req_ready),
      .req_bits_i (req_bits),
      .req_last_i (req_last),
      .out_valid_o(out_valid),
      .out_ready_i(out_ready),
      .out_bits_o (out_bits),
      .out_last_o (out_last),
      .out_idx_o  (out_idx)
`ifdef RR_STREAM_ARBITER_GRANT_CNT_EN
      ,
      .grant_cnt_o(grant_cnt)
`endif
   );

   always #5 clk = ~clk;

   task automatic checkValue(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic modelReset();
      m_ptr   = 0;
      m_owner = -1;
      for (int i = 0; i < 4; i++) m_cnt[i] = 0;
   endtask

   function automatic int modelSel();
      if (m_owner >= 0) return m_owner;
      for (int k = 0; k < 4; k++) begin
         int j;
         j = (m_ptr + k) % 4;
         if (req_valid[j[1:0]]) return j;
      end
      return 0;
   endfunction

   task automatic applyStimulus(input logic [3:0] v, input logic [3:0] l, input logic r);
      req_valid = v;
      req_last  = l;
      out_ready = r;
   endtask

   // Compare every output against the model's view of the current inputs.
   task automatic checkOutput(input string name);
      logic [3:0] exp_ready;
      p_sel   = modelSel();
      p_valid = req_valid[p_sel[1:0]];
      p_last  = req_last[p_sel[1:0]];
      p_fire  = p_valid && out_ready;
      exp_ready = 4'b0000;
      if (m_owner >= 0 || req_valid != 4'b0000) exp_ready[p_sel[1:0]] = out_ready;
      checkValue({name, ".valid"}, 32'(out_valid), 32'(p_valid));
      checkValue({name, ".idx"},   32'(out_idx),   32'(p_sel));
      checkValue({name, ".bits"},  out_bits,       req_bits[p_sel[1:0]]);
      checkValue({name, ".last"},  32'(out_last),  32'(p_last));
      checkValue({name, ".ready"}, 32'(req_ready), 32'(exp_ready));
   endtask

   task automatic modelAdvance();
      if (p_fire && p_last) begin
         m_owner = -1;
         m_ptr   = (p_sel + 1) % 4;
         if (m_cnt[p_sel] < 65535) m_cnt[p_sel]++;
      end else if (p_valid) begin
         m_owner = p_sel;
      end else begin
         m_owner = -1;
      end
   endtask

   // Called at posedge+1; samples at the falling edge, returns at next posedge+1.
   task automatic runCycle(input logic [3:0] v, input logic [3:0] l, input logic r,
                           input int exp_idx, input string name);
      applyStimulus(v, l, r);
      #4;
      checkOutput(name);
      if (exp_idx >= 0) checkValue({name, ".plan_idx"}, 32'(out_idx), 32'(exp_idx));
      @(posedge clk);
      modelAdvance();
      #1;
   endtask

   task automatic doReset();
      rst_n = 1'b0;
      applyStimulus(4'b0000, 4'b0000, 1'b0);
      modelReset();
      @(posedge clk);
      #4;
      rst_n = 1'b1;
      @(posedge clk);
      #1;
   endtask

   initial begin
      clk = 1'b0;
      rst_n = 1'b0;
      for (int i = 0; i < 4; i++) begin
         req_bits[i] = 32'hC0DE_0000 + 32'(i);
         rem[i] = 0;
      end
      applyStimulus(4'b0000, 4'b0000, 1'b0);
      modelReset();

      // Reset state with nothing valid
      @(posedge clk);
      #1;
      applyStimulus(4'b0000, 4'b1111, 1'b1);
      #4;
      checkOutput("reset");
      checkValue("reset.idx0",   32'(out_idx),   32'd0);
      checkValue("reset.valid0", 32'(out_valid), 32'd0);
      checkValue("reset.ready0", 32'(req_ready), 32'd0);
      checkValue("reset.bits0",  out_bits,       32'hC0DE_0000);
      rst_n = 1'b1;
      @(posedge clk);
      #1;

      // Rotation 0..3 twice, then a 3-beat burst from 2 while 1 waits
      for (int i = 0; i < 8; i++)
         vecs[i] = '{4'b1111, 4'b1111, 1'b1, 1'b1, i % 4, 4'(1 << (i % 4))};
      vecs[8]  = '{4'b0010, 4'b0010, 1'b1, 1'b1, 1, 4'b0010};
      vecs[9]  = '{4'b0110, 4'b0010, 1'b1, 1'b1, 2, 4'b0100};
      vecs[10] = '{4'b0110, 4'b0010, 1'b1, 1'b1, 2, 4'b0100};
      vecs[11] = '{4'b0110, 4'b0110, 1'b1, 1'b1, 2, 4'b0100};
      vecs[12] = '{4'b0010, 4'b0010, 1'b1, 1'b1, 1, 4'b0010};
      vecs[13] = '{4'b0000, 4'b0000, 1'b1, 1'b0, 0, 4'b0000};
      for (int i = 0; i < 14; i++) begin
         applyStimulus(vecs[i].valid, vecs[i].last, vecs[i].ready);
         #4;
         checkOutput("table");
         checkValue($sformatf("table%0d.idx", i),   32'(out_idx),   32'(vecs[i].exp_idx));
         checkValue($sformatf("table%0d.valid", i), 32'(out_valid), 32'(vecs[i].exp_valid));
         checkValue($sformatf("table%0d.ready", i), 32'(req_ready), 32'(vecs[i].exp_ready));
         @(posedge clk);
         modelAdvance();
         #1;
      end

      // Stall: 0 holds the grant while 3 arrives, then 0 fires before 3
      runCycle(4'b0001, 4'b1111, 1'b0, 0, "stall_c1");
      for (int c = 2; c <= 5; c++) begin
         runCycle(4'b1001, 4'b1111, 1'b0, 0, "stall_hold");
         checkValue("stall.bits_stable", out_bits, 32'hC0DE_0000);
      end
      runCycle(4'b1001, 4'b1111, 1'b1, 0, "stall_fire0");
      runCycle(4'b1000, 4'b1111, 1'b1, 3, "stall_then3");
      // Requester 3 completing wraps the pointer back to 0
      runCycle(4'b0011, 4'b1111, 1'b1, 0, "wrap_grant0");

      // Reset in the middle of a 4-beat burst from requester 1
      runCycle(4'b0010, 4'b0000, 1'b1, 1, "burst1_b1");
      runCycle(4'b0010, 4'b0000, 1'b1, 1, "burst1_b2");
      rst_n = 1'b0;
      modelReset();
      applyStimulus(4'b0011, 4'b0011, 1'b0);
      #4;
      checkOutput("in_reset");
      checkValue("in_reset.idx", 32'(out_idx), 32'd0);
      rst_n = 1'b1;
      @(posedge clk);
      modelAdvance();
      #1;
      runCycle(4'b0011, 4'b0011, 1'b1, 0, "post_reset_grant0");

`ifdef RR_STREAM_ARBITER_GRANT_CNT_EN
      doReset();
      for (int i = 0; i < 10; i++) runCycle(4'b0100, 4'b0100, 1'b1, 2, "cnt_single2");
      for (int i = 0; i < 3; i++) runCycle(4'b0001, 4'b0000, 1'b1, 0, "cnt_burst0");
      runCycle(4'b0001, 4'b0001, 1'b1, 0, "cnt_burst0_last");
      applyStimulus(4'b0000, 4'b0000, 1'b0);
      #4;
      checkValue("grant_cnt2", 32'(grant_cnt[2]), 32'd10);
      checkValue("grant_cnt0", 32'(grant_cnt[0]), 32'd1);
      checkValue("grant_cnt1", 32'(grant_cnt[1]), 32'd0);
      @(posedge clk);
      #1;
`endif

      // Random contract-respecting bursts against the model
      doReset();
      for (int c = 0; c < 1500; c++) begin
         logic [3:0] v;
         logic [3:0] l;
         for (int i = 0; i < 4; i++) begin
            if (rem[i] == 0 && $urandom_range(0, 2) == 0) begin
               rem[i] = int'($urandom_range(1, 3));
               req_bits[i] = $urandom;
            end
            v[i] = (rem[i] > 0);
            l[i] = (rem[i] == 1);
         end
         runCycle(v, l, ($urandom_range(0, 3) != 0), -1, "rand");
         if (p_fire) begin
            rem[p_sel]--;
            req_bits[p_sel[1:0]] = $urandom;
         end
      end
`ifdef RR_STREAM_ARBITER_GRANT_CNT_EN
      applyStimulus(4'b0000, 4'b0000, 1'b0);
      #4;
      for (int i = 0; i < 4; i++)
         checkValue($sformatf("rand_grant_cnt%0d", i), 32'(grant_cnt[i]), 32'(m_cnt[i]));
`endif

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/rr_stream_arbiter.md
Name: rr_stream_arbiter

Overview:
- Round-robin, burst-aware N:1 arbiter for ready/valid streams.
- Shares one downstream FIFO enqueue port between NUM_REQ requesters.
- Selection is combinational, so the arbiter adds zero cycles of latency.
- Grant is sticky: it holds across a stall and across a multi-beat burst, ending only when the beat with `last` is accepted.
- Typical use: several lane/engine outputs merged into one shared Queue.

Parameters:
- NUM_REQ, 4, number of requesters; legal range 2..32.
- T, logic [31:0], payload type (parameter type).
- IDX_W, $clog2(NUM_REQ), width of the requester index (derived, not overridden).

Ports:
- clk_i  in  1  clock, rising edge.
- rst_ni  in  1  asynchronous active-low reset.
- req_valid_i  in  NUM_REQ  per-requester valid.
- req_ready_o  out  NUM_REQ  per-requester ready.
- req_bits_i  in  NUM_REQ x T  per-requester payload.
- req_last_i  in  NUM_REQ  per-requester end-of-burst marker.
- out_valid_o  out  1  downstream valid.
- out_ready_i  in  1  downstream ready (e.g. queue enq_ready).
- out_bits_o  out  T  payload of the granted requester.
- out_last_o  out  1  last flag of the granted requester.
- out_idx_o  out  IDX_W  index of the granted requester.

Behaviour:
- State: rr_ptr (IDX_W), lock_q (1), lock_idx_q (IDX_W).
- Reset values: rr_ptr=0, lock_q=0, lock_idx_q=0.
- Outputs are combinational. With all req_valid_i=0: out_valid_o=0, req_ready_o=0, out_idx_o=0, out_bits_o=req_bits_i[0], out_last_o=req_last_i[0].
- Select, lock_q=0: sel = first i with req_valid_i[i]=1, searching rr_ptr, rr_ptr+1, ... with wrap NUM_REQ-1 -> 0.
- Select, lock_q=1: sel = lock_idx_q, regardless of other valids.
- Outputs from sel: out_valid_o = req_valid_i[sel]; out_bits_o, out_last_o and out_idx_o follow sel.
- Ready: req_ready_o[sel] = out_ready_i; every other req_ready_o bit = 0. Ready of the unselected requesters never depends on their own valid.
- Handshake: fire = out_valid_o & out_ready_i. Exactly one requester transfers per fire.
- Lock update each cycle: lock_q <= out_valid_o & ~(fire & out_last_o); lock_idx_q <= sel.
  - The grant therefore holds while stalled (valid & !ready).
  - It also holds after a non-last beat fires.
- rr_ptr update: on fire & out_last_o, rr_ptr <= (sel == NUM_REQ-1) ? 0 : sel+1. Otherwise rr_ptr is unchanged.
- Single-beat transfers use last=1 every beat, so each beat rotates priority.
- Requester contract: once valid is asserted, the requester keeps it high until its beat fires. Inside a burst it must also keep valid high until last fires.
- Lock with req_valid_i[lock_idx_q]=0 (contract violation or mid-burst gap): out_valid_o=0, the grant stays locked, and no other requester is served.
- Simultaneous valids: exactly one is granted per burst. Fairness: every valid requester is granted within NUM_REQ bursts.
- Reset mid-burst: state returns to reset values immediately (asynchronous). The next grant starts from index 0.
- NUM_REQ not a power of 2: the wrap is explicit, so rr_ptr never holds a value >= NUM_REQ.

Optional Feature:
- Macro: RR_STREAM_ARBITER_GRANT_CNT_EN.
- Defined:
  - Adds output grant_cnt_o, NUM_REQ x 16.
  - The counter for requester sel increments on each fire with out_last_o=1, i.e. one count per completed burst.
  - Counters saturate at 16'hFFFF and reset to 0.
- Undefined: the port and the counters are absent. All other behaviour is identical.

Decomposition:
- Package rr_arb_pkg holds:
  - the maximum NUM_REQ constant (32);
  - the grant counter width (16);
  - a function wrap_inc(idx, n) for the pointer increment.
- Sub-module rr_prio_select: combinational find-first-set starting at a pointer with wrap. Inputs: valid vector and rr_ptr. Outputs: sel index and any_valid.
- The top level holds the lock register, the rr_ptr register, the mux and the optional counters.

Test Plan (NUM_REQ=4):
- Reset, then all 4 requesters valid with last=1 and out_ready=1 held for 8 cycles -> out_idx_o sequence 0,1,2,3,0,1,2,3.
- Requester 2 sends a 3-beat burst (last on beat 3) while requester 1 is valid throughout, starting with rr_ptr=2 -> beats 2,2,2, then idx 1; req_ready_o[1]=0 during the burst.
- Requester 0 valid, out_ready=0 for 5 cycles, requester 3 raises valid in cycle 2 -> out_idx_o stays 0 and out_bits_o stays stable; after ready rises, requester 0 fires first, then requester 3.
- Only requester 3 valid, last=1, fires -> rr_ptr wraps to 0; then requesters 0 and 1 both valid -> 0 is granted.
- rst_ni asserted after beat 2 of a 4-beat burst from requester 1 -> lock_q=0 and rr_ptr=0 immediately; with requesters 0 and 1 valid after reset, 0 is granted.
- With RR_STREAM_ARBITER_GRANT_CNT_EN defined: 10 single-beat bursts from requester 2 and one 4-beat burst from requester 0 -> grant_cnt_o[2]=10, grant_cnt_o[0]=1.
